// File: rtl/key_conditioner.sv
// Multi-channel key conditioner: synchronizer, counter debouncer and edge pulses
// per channel, with optional auto-repeat of the press pulse while a key is held.

module key_lane #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int INVERT          = 0,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);
    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          INV  = (INVERT != 0);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;
    logic                   accept;
    logic                   rep_hit;

    assign s      = sync[SYNC_STAGES-1];
    assign accept = (s != level) && (cnt == CMAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], raw ^ INV};
            press <= (accept & s) | rep_hit;
            rel   <= accept & ~s;
            if (s == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    generate
        if (REPEAT_CYCLES > 0) begin : g_rep
            localparam int            RW   = $clog2(REPEAT_CYCLES);
            localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYCLES - 1);
            logic [RW-1:0] rcnt;

            // A release being accepted this cycle suppresses the repeat pulse.
            assign rep_hit = level && !accept && (rcnt == RMAX);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    rcnt <= '0;
                else if (accept || !level || rcnt == RMAX)
                    rcnt <= '0;
                else
                    rcnt <= rcnt + 1'b1;
            end
        end else begin : g_norep
            assign rep_hit = 1'b0;
        end
    endgenerate
endmodule

module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int INVERT          = 0,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);
    generate
        for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
            key_lane #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .INVERT         (INVERT),
                .REPEAT_CYCLES  (REPEAT_CYCLES)
            ) u_lane (
                .clk  (clk),
                .reset(reset),
                .raw  (key_in[i]),
                .level(key_level[i]),
                .press(key_press[i]),
                .rel  (key_release[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench: default, active-low and auto-repeat instances driven from one sequence.

module tb_key_conditioner;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] k0, k1, k2;
    logic [3:0] lv0, pr0, rl0;
    logic [3:0] lv1, pr1, rl1;
    logic [3:0] lv2, pr2, rl2;
    int checks   = 0;
    int failures = 0;
    int npress;

    always #5 clk = ~clk;

    key_conditioner d0 (.clk(clk), .reset(reset), .key_in(k0),
                        .key_level(lv0), .key_press(pr0), .key_release(rl0));
    key_conditioner #(.INVERT(1)) d1 (.clk(clk), .reset(reset), .key_in(k1),
                        .key_level(lv1), .key_press(pr1), .key_release(rl1));
    key_conditioner #(.REPEAT_CYCLES(8)) d2 (.clk(clk), .reset(reset), .key_in(k2),
                        .key_level(lv2), .key_press(pr2), .key_release(rl2));

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        k0 = 4'b0000; k1 = 4'b1111; k2 = 4'b0000;
        step(); step();
        chk("rst_lv0", lv0, 4'b0); chk("rst_pr0", pr0, 4'b0); chk("rst_rl0", rl0, 4'b0);
        chk("rst_lv1", lv1, 4'b0); chk("rst_lv2", lv2, 4'b0);
        @(negedge clk) reset = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("idle_lv1_e%0d", e), lv1, 4'b0);
            chk($sformatf("idle_pr1_e%0d", e), pr1, 4'b0);
            chk($sformatf("idle_pr0_e%0d", e), pr0, 4'b0);
        end

        // 1: press on channel 0, accepted on edge 6
        k0 = 4'b0001;
        for (int e = 1; e <= 20; e++) begin
            step();
            chk($sformatf("t1_lv_e%0d", e), lv0, (e >= 6) ? 4'b0001 : 4'b0000);
            chk($sformatf("t1_pr_e%0d", e), pr0, (e == 6) ? 4'b0001 : 4'b0000);
            chk($sformatf("t1_rl_e%0d", e), rl0, 4'b0000);
        end

        // 2: 3-cycle glitch on channel 1 is rejected
        k0 = 4'b0011;
        step(); step(); step();
        k0 = 4'b0001;
        for (int e = 1; e <= 10; e++) begin
            step();
            chk($sformatf("t2_lv_e%0d", e), lv0, 4'b0001);
            chk($sformatf("t2_pr_e%0d", e), pr0, 4'b0000);
            chk($sformatf("t2_rl_e%0d", e), rl0, 4'b0000);
        end

        // 3: release channel 0
        k0 = 4'b0000;
        for (int e = 1; e <= 12; e++) begin
            step();
            chk($sformatf("t3_lv_e%0d", e), lv0, (e < 6) ? 4'b0001 : 4'b0000);
            chk($sformatf("t3_rl_e%0d", e), rl0, (e == 6) ? 4'b0001 : 4'b0000);
            chk($sformatf("t3_pr_e%0d", e), pr0, 4'b0000);
        end

        // 4: active-low instance, key 2 pulled low
        k1 = 4'b1011;
        for (int e = 1; e <= 10; e++) begin
            step();
            chk($sformatf("t4_lv_e%0d", e), lv1, (e >= 6) ? 4'b0100 : 4'b0000);
            chk($sformatf("t4_pr_e%0d", e), pr1, (e == 6) ? 4'b0100 : 4'b0000);
            chk($sformatf("t4_rl_e%0d", e), rl1, 4'b0000);
        end

        // 5: auto-repeat every 8 cycles on channel 3
        k2 = 4'b1000;
        npress = 0;
        for (int e = 1; e <= 31; e++) begin
            step();
            if (pr2[3]) npress++;
            chk($sformatf("t5_pr_e%0d", e), pr2,
                (e >= 6 && ((e - 6) % 8) == 0) ? 4'b1000 : 4'b0000);
            chk($sformatf("t5_lv_e%0d", e), lv2, (e >= 6) ? 4'b1000 : 4'b0000);
        end
        k2 = 4'b0000;
        for (int e = 1; e <= 12; e++) begin
            step();
            chk($sformatf("t5r_rl_e%0d", e), rl2, (e == 6) ? 4'b1000 : 4'b0000);
            chk($sformatf("t5r_pr_e%0d", e), pr2, 4'b0000);
        end
        checks++;
        assert (npress == 4) else begin
            failures++;
            $error("FAIL t5_count observed=%0d expected=4", npress);
        end

        // 6: async reset while channel 0 pressed and channel 1 mid-debounce
        k0 = 4'b0001;
        for (int e = 1; e <= 6; e++) step();
        chk("t6_pre_lv", lv0, 4'b0001);
        k0 = 4'b0011;
        step(); step(); step(); step();
        #3 reset = 1'b0;
        #1;
        chk("t6_rst_lv", lv0, 4'b0000);
        chk("t6_rst_pr", pr0, 4'b0000);
        chk("t6_rst_rl", rl0, 4'b0000);
        k0 = 4'b0001;
        @(negedge clk) reset = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            chk($sformatf("t6_lv_e%0d", e), lv0, (e >= 6) ? 4'b0001 : 4'b0000);
            chk($sformatf("t6_pr_e%0d", e), pr0, (e == 6) ? 4'b0001 : 4'b0000);
            chk($sformatf("t6_rl_e%0d", e), rl0, 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
